wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Owns the single register-file write port (RegWrite/Write_register/Write_data) at the WB end of the pipeline.
//  Merges in-order pipeline results with out-of-order results from the multi-cycle mul/div unit (MDU).
//  MDU results are buffered in a small FIFO; the block registers the commit and drops writes to register 0.
//  Flags registers with pending, uncommitted writes so ID can stall on RAW/WAW hazards.
// PARAMETERS
//  DATA_W        32  register data width
//  ADDR_W        5   register index width
//  DEPTH         2   MDU result FIFO entries; power of 2, >= 2
//  STARVE_LIMIT  4   cycles a FIFO head may wait before stall_pipe asserts; >= 1
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       asynchronous, active-high reset
//  pipe_valid      in   1       in-order WB result valid this cycle (no backpressure)
//  pipe_rd         in   ADDR_W  destination register of pipe result
//  pipe_data       in   DATA_W  pipe result data
//  mdu_valid       in   1       MDU result offered
//  mdu_ready       out  1       FIFO can accept; transfer when mdu_valid & mdu_ready
//  mdu_rd          in   ADDR_W  MDU destination register
//  mdu_data        in   DATA_W  MDU result data
//  RegWrite        out  1       register-file write enable (registered)
//  Write_register  out  ADDR_W  register-file write index (registered)
//  Write_data      out  DATA_W  register-file write data (registered)
//  stall_pipe      out  1       request that ID/EX inject a bubble so the FIFO can drain
//  rs_query_1      in   ADDR_W  ID source register 1
//  rs_query_2      in   ADDR_W  ID source register 2
//  pending_1       out  1       rs_query_1 has an uncommitted write in this block
//  pending_2       out  1       rs_query_2 has an uncommitted write in this block
// BEHAVIOUR
//  Reset (async, immediate): RegWrite=0, Write_register=0, Write_data=0, FIFO empty, starve counter=0,
//   stall_pipe=0. mdu_ready=0 while rst is high; it is 1 in the first cycle after release. Reset mid-burst discards all buffered data.
//  Commit select, each edge, highest priority first:
//   1. pipe_valid & pipe_rd!=0: register pipe_rd/pipe_data; the FIFO holds.
//   2. else FIFO non-empty: pop the head and register it.
//   3. else RegWrite<=0; Write_register/Write_data hold their values.
//  Latency: pipe result sampled at edge E -> RegWrite high in the cycle after E. An MDU result accepted at edge E
//   can commit at edge E+1 at the earliest, so it is visible 2 cycles after acceptance; the FIFO is never bypassed.
//  Register 0: pipe writes with rd=0 are ignored and do not block a FIFO pop. MDU results with rd=0 are
//   accepted (handshake completes) but not enqueued.
//  FIFO: mdu_ready = (count < DEPTH), computed from current count only. When full, ready=0 even if a pop
//   happens in the same cycle. Simultaneous push and pop when not full: count unchanged. Read/write pointers
//   wrap modulo DEPTH. Ordering is FIFO order.
//  Starvation: the counter increments each cycle the FIFO is non-empty and the head is not popped. It clears on
//   a pop or when the FIFO is empty, and saturates at STARVE_LIMIT. stall_pipe = (count == STARVE_LIMIT), registered.
//   If pipe_valid arrives while stall_pipe=1, the pipe still wins; the counter stays saturated.
//  Hazards (combinational): pending_n = rs_query_n!=0 and rs_query_n matches either
//   (a) any valid FIFO entry, or (b) Write_register while RegWrite=1 (the write lands at the next edge).
//   The issuer must not issue a pipe write to a register pending in the FIFO. Given that, the block performs no WAW reordering.
// TESTING
//  Reset: assert rst mid-cycle -> all outputs 0 immediately, mdu_ready=0; release -> mdu_ready=1 next cycle.
//  pipe_valid, rd=5, data=0xDEADBEEF at edge E -> RegWrite=1, Write_register=5, Write_data=0xDEADBEEF after E; rd=0 -> RegWrite stays 0.
//  MDU rd=7 accepted at E, no pipe traffic -> rd=7 commits at E+1; pending_1=1 for rs_query_1=7 until the cycle after the write edge.
//  Fill the FIFO with rd=3 then rd=4 while pipe_valid=1 continuously -> mdu_ready=0; stall_pipe=1 after 4 wait cycles.
//   Drop pipe_valid -> rd=3 commits, then rd=4; stall_pipe clears; mdu_ready returns to 1.
//  Simultaneous push and pop with count=1 -> count stays 1; pointers wrap correctly over 10 back-to-back transfers; commit order matches acceptance order.
//  MDU rd=0 -> handshake completes, nothing enqueued, no RegWrite, pending never asserts.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//   Owns the single register-file write port at the WB end of the pipeline.
//   In-order pipeline results always win the port. Out-of-order results from
//   the multi-cycle mul/div unit (MDU) are buffered in a small FIFO and drain
//   into free cycles. Writes to register 0 are discarded. A starvation counter
//   raises stall_pipe when the FIFO head has waited too long, and the pending_*
//   outputs flag registers with uncommitted writes so ID can stall on hazards.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   pipe_valid/rd/data       in-order WB result (no backpressure)
//   mdu_valid/ready/rd/data  MDU result handshake (transfer on valid & ready)
//   RegWrite                 registered register-file write enable
//   Write_register           registered register-file write index
//   Write_data               registered register-file write data
//   stall_pipe               ask ID/EX for a bubble so the FIFO can drain
//   rs_query_1/2             ID source registers to check
//   pending_1/2              source register has an uncommitted write here
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  output logic              stall_pipe,
  input  logic [ADDR_W-1:0] rs_query_1,
  input  logic [ADDR_W-1:0] rs_query_2,
  output logic              pending_1,
  output logic              pending_2
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [SCNT_W-1:0] LIMIT_C = SCNT_W'(STARVE_LIMIT);

  // FIFO storage and control
  logic [ADDR_W-1:0] fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [SCNT_W-1:0] starve_cnt;
  logic [SCNT_W-1:0] starve_next;

  logic pipe_win;
  logic fifo_empty;
  logic push;
  logic pop;

  // Pipe results to r0 are not real writes, so they never steal the port.
  assign pipe_win   = pipe_valid && (pipe_rd != '0);
  assign fifo_empty = (count == '0);
  assign pop        = !pipe_win && !fifo_empty;

  // Ready depends on the current occupancy only: a full FIFO refuses even when
  // its head is leaving this cycle, which keeps ready free of the pipe path.
  assign mdu_ready  = !rst && (count < DEPTH_C);

  // r0 results complete the handshake but are never stored.
  assign push       = mdu_valid && mdu_ready && (mdu_rd != '0);

  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || pop) begin
      starve_next = '0;
    end else if (starve_cnt != LIMIT_C) begin
      starve_next = starve_cnt + SCNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_vld   <= '0;
      starve_cnt <= '0;
      stall_pipe <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr           <= rd_ptr + PTR_W'(1);
        fifo_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr           <= wr_ptr + PTR_W'(1);
        fifo_vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
      stall_pipe <= (starve_next == LIMIT_C);
    end
  end

  // NOTE: the payload array has no reset; fifo_vld and count alone decide
  // which slots are meaningful, so clearing the data would only cost area.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mdu_rd;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

  // Commit register: pipe first, then FIFO head, else idle with index/data held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else if (pipe_win) begin
      RegWrite       <= 1'b1;
      Write_register <= pipe_rd;
      Write_data     <= pipe_data;
    end else if (pop) begin
      RegWrite       <= 1'b1;
      Write_register <= fifo_rd[rd_ptr];
      Write_data     <= fifo_data[rd_ptr];
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Hazard lookup: any buffered entry, or the write that lands at the next edge.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    logic hit_1;
    logic hit_2;
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_rd[i] == rs_query_1)) hit_1 = 1'b1;
      if (fifo_vld[i] && (fifo_rd[i] == rs_query_2)) hit_2 = 1'b1;
    end
    if (RegWrite && (Write_register == rs_query_1)) hit_1 = 1'b1;
    if (RegWrite && (Write_register == rs_query_2)) hit_2 = 1'b1;
    pending_1 = (rs_query_1 != '0) && hit_1;
    pending_2 = (rs_query_2 != '0) && hit_2;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_write_arbiter
//   Scoreboard bench. A reference process steps a queue-based model of the
//   arbiter on every rising edge and pushes each expected register-file write
//   (tagged with its cycle) into exp_q. A monitor on the falling edge pops and
//   compares whenever RegWrite is seen, and also compares mdu_ready,
//   stall_pipe and pending_* against the model each cycle.
// -----------------------------------------------------------------------------
module tb_wb_write_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              rst;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_data;
  logic              stall_pipe;
  logic [ADDR_W-1:0] rs_query_1;
  logic [ADDR_W-1:0] rs_query_2;
  logic              pending_1;
  logic              pending_2;

  wb_write_arbiter #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_valid    (pipe_valid),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_rd        (mdu_rd),
    .mdu_data      (mdu_data),
    .RegWrite      (RegWrite),
    .Write_register(Write_register),
    .Write_data    (Write_data),
    .stall_pipe    (stall_pipe),
    .rs_query_1    (rs_query_1),
    .rs_query_2    (rs_query_2),
    .pending_1     (pending_1),
    .pending_2     (pending_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    int                cyc;
  } commit_t;

  entry_t            fifo_m[$];   // model of buffered MDU results, oldest first
  commit_t           exp_q[$];    // expected register-file writes
  int                cyc;
  bit                rw_m;        // model: a write is presented this cycle
  logic [ADDR_W-1:0] wr_reg_m;
  logic [DATA_W-1:0] wr_data_m;
  int                starve_m;

  function automatic bit pend_m(input logic [ADDR_W-1:0] q);
    if (q == '0) return 1'b0;
    foreach (fifo_m[i]) if (fifo_m[i].rd == q) return 1'b1;
    return rw_m && (wr_reg_m == q);
  endfunction

  task automatic model_commit(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    commit_t c;
    c.rd = rd; c.data = data; c.cyc = cyc;
    exp_q.push_back(c);
    rw_m = 1'b1; wr_reg_m = rd; wr_data_m = data;
  endtask

  // One clock of the arbiter, from the behavioural rules.
  task automatic model_step();
    bit     ready, pwin, had_data, popped;
    entry_t h, e;
    ready    = fifo_m.size() < DEPTH;
    pwin     = pipe_valid && (pipe_rd != '0);
    had_data = fifo_m.size() != 0;
    popped   = !pwin && had_data;
    if (pwin) begin
      model_commit(pipe_rd, pipe_data);
    end else if (popped) begin
      h = fifo_m.pop_front();
      model_commit(h.rd, h.data);
    end else begin
      rw_m = 1'b0;
    end
    if (!had_data || popped) starve_m = 0;
    else if (starve_m < STARVE_LIMIT) starve_m = starve_m + 1;
    if (mdu_valid && ready && (mdu_rd != '0)) begin
      e.rd = mdu_rd; e.data = mdu_data;
      fifo_m.push_back(e);
    end
  endtask

  // Reference process: reacts to async reset immediately, otherwise steps per edge.
  initial begin
    cyc = 0; rw_m = 0; wr_reg_m = '0; wr_data_m = '0; starve_m = 0;
    forever begin
      @(posedge clk or posedge rst);
      cyc++;
      if (rst) begin
        fifo_m.delete();
        exp_q.delete();
        rw_m = 0; wr_reg_m = '0; wr_data_m = '0; starve_m = 0;
      end else begin
        model_step();
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    commit_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (RegWrite) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", RegWrite, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("commit_cycle", cyc, e.cyc);
            check("commit_rd", Write_register, e.rd);
            check("commit_data", Write_data, e.data);
          end
        end else begin
          if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missing_write", RegWrite, 1'b1);
          end
          check("hold_rd", Write_register, wr_reg_m);
          check("hold_data", Write_data, wr_data_m);
        end
        check("mdu_ready", mdu_ready, fifo_m.size() < DEPTH);
        check("stall_pipe", stall_pipe, starve_m == STARVE_LIMIT);
        check("pending_1", pending_1, pend_m(rs_query_1));
        check("pending_2", pending_2, pend_m(rs_query_2));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    mdu_valid  = 1'b0; mdu_rd  = '0; mdu_data  = '0;
  endtask

  task automatic set_pipe(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    pipe_valid = v; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic set_mdu(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    mdu_valid = v; mdu_rd = rd; mdu_data = d;
  endtask

  // Assert reset mid-cycle and check that outputs clear without waiting for a clock.
  task automatic mid_cycle_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_Write_register", Write_register, '0);
    check("rst_Write_data", Write_data, '0);
    check("rst_stall_pipe", stall_pipe, 1'b0);
    check("rst_mdu_ready", mdu_ready, 1'b0);
    check("rst_pending_1", pending_1, 1'b0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("release_mdu_ready", mdu_ready, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    rs_query_1 = 5'd3;
    rs_query_2 = 5'd4;
    #2;
    check("init_RegWrite", RegWrite, 1'b0);
    check("init_mdu_ready", mdu_ready, 1'b0);
    check("init_stall_pipe", stall_pipe, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("release_mdu_ready", mdu_ready, 1'b1);
    tick();

    // Pipe write to r5, then a pipe write to r0 that must not commit.
    set_pipe(1'b1, 5'd5, 32'hDEAD_BEEF); tick();
    set_pipe(1'b1, 5'd0, 32'h1234_5678); tick();
    idle_inputs(); tick(); tick();

    // Lone MDU result to r7; pending_1 watches it through FIFO and commit.
    rs_query_1 = 5'd7;
    set_mdu(1'b1, 5'd7, 32'h0000_0777); tick();
    idle_inputs(); repeat (4) tick();

    // Fill the FIFO behind continuous pipe traffic until stall_pipe rises,
    // then release the port and watch r3, r4 drain in order.
    rs_query_1 = 5'd3;
    for (int i = 0; i < 9; i++) begin
      set_pipe(1'b1, ADDR_W'(10 + i), $urandom);
      if (i == 0)      set_mdu(1'b1, 5'd3, 32'h3333_3333);
      else if (i == 1) set_mdu(1'b1, 5'd4, 32'h4444_4444);
      else if (i == 2) set_mdu(1'b1, 5'd6, 32'h6666_6666); // refused while full
      else             set_mdu(1'b0, '0, '0);
      tick();
    end
    idle_inputs(); repeat (4) tick();

    // Count held at one while pushing and popping every cycle; pointers wrap.
    set_pipe(1'b1, 5'd20, $urandom); set_mdu(1'b1, 5'd1, $urandom); tick();
    for (int i = 0; i < 10; i++) begin
      set_pipe(1'b0, '0, '0);
      set_mdu(1'b1, ADDR_W'(2 + i), $urandom);
      rs_query_2 = ADDR_W'(2 + i);
      tick();
    end
    idle_inputs(); repeat (3) tick();

    // MDU result to r0: accepted, dropped, never pending.
    rs_query_1 = 5'd0; rs_query_2 = 5'd0;
    set_mdu(1'b1, 5'd0, 32'hBAD0_0000); tick();
    idle_inputs(); repeat (3) tick();

    // Randomised traffic with bursty pipe pressure, plus a reset mid-burst.
    for (int i = 0; i < 1500; i++) begin
      int pipe_pct;
      pipe_pct = ((i / 100) % 2 == 0) ? 90 : 35;
      if (i == 700) begin
        set_pipe(1'b1, 5'd9, $urandom); set_mdu(1'b1, 5'd11, $urandom); tick();
        set_pipe(1'b1, 5'd9, $urandom); set_mdu(1'b1, 5'd12, $urandom); tick();
        rs_query_1 = 5'd11;
        mid_cycle_reset();
      end
      set_pipe($urandom_range(0, 99) < pipe_pct, ADDR_W'($urandom_range(0, 7)), $urandom);
      set_mdu($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)), $urandom);
      rs_query_1 = ADDR_W'($urandom_range(0, 7));
      rs_query_2 = ADDR_W'($urandom_range(0, 7));
      tick();
    end

    // Quiet drain: everything buffered must commit within a bounded time.
    idle_inputs();
    repeat (DEPTH + 4) tick();
    @(negedge clk);
    check("drain_RegWrite", RegWrite, 1'b0);
    check("drain_mdu_ready", mdu_ready, 1'b1);
    check("drain_stall_pipe", stall_pipe, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
